// File: rtl/full_adder_using_mux.sv
// -----------------------------------------------------------------------------
// full_adder_using_mux
//
// Purpose:
//   Ripple-carry adder in which every sum and carry bit comes out of a 4:1
//   multiplexer. There are no XOR/AND/OR gates in the datapath. Each bit cell
//   uses two mux4 instances: one for sum and one for carry. Their select is
//   {A[i], B[i]} and their data inputs are built from the incoming carry.
//   The outputs can optionally be registered.
//
// Parameters:
//   WIDTH        operand width and number of rippled cells (>= 1)
//   REGISTER_OUT 0: Sum/Cout combinational; 1: Sum/Cout registered on clk
//
// Ports:
//   clk    clock, used only when REGISTER_OUT=1
//   rst_n  async active-low reset, clears output registers (REGISTER_OUT=1)
//   A, B   addends
//   Cin    carry into bit 0
//   Sum    (A + B + Cin) mod 2^WIDTH
//   Cout   carry out of the MSB cell
// -----------------------------------------------------------------------------

// 4:1 mux primitive: y_o = d[sel_i].
module mux4 (
    input  logic [1:0] sel_i,
    input  logic       d0_i,
    input  logic       d1_i,
    input  logic       d2_i,
    input  logic       d3_i,
    output logic       y_o
);
    always_comb begin
        y_o = d0_i;
        case (sel_i)
            2'd0: y_o = d0_i;
            2'd1: y_o = d1_i;
            2'd2: y_o = d2_i;
            2'd3: y_o = d3_i;
            default: y_o = d0_i;
        endcase
    end
endmodule

module full_adder_using_mux #(
    parameter int unsigned WIDTH        = 1,
    parameter bit          REGISTER_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    // carry[i] is the carry into cell i; carry[WIDTH] is the final carry out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;

    assign carry[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic [1:0] sel;
        logic       c;
        logic       c_n;

        assign sel = {A[i], B[i]};
        assign c   = carry[i];
        assign c_n = ~c;

        // The sum is c when A==B and ~c when A!=B.
        mux4 u_sum_mux (
            .sel_i (sel),
            .d0_i  (c),
            .d1_i  (c_n),
            .d2_i  (c_n),
            .d3_i  (c),
            .y_o   (sum_d[i])
        );

        // The carry is 0 when both bits are 0, 1 when both are 1, and the
        // incoming carry otherwise.
        mux4 u_carry_mux (
            .sel_i (sel),
            .d0_i  (1'b0),
            .d1_i  (c),
            .d2_i  (c),
            .d3_i  (1'b1),
            .y_o   (carry[i+1])
        );
    end

    if (REGISTER_OUT) begin : g_reg
        logic [WIDTH-1:0] sum_q;
        logic             cout_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sum_q  <= '0;
                cout_q <= 1'b0;
            end else begin
                sum_q  <= sum_d;
                cout_q <= carry[WIDTH];
            end
        end

        assign Sum  = sum_q;
        assign Cout = cout_q;
    end else begin : g_comb
        // The clock and reset are intentionally unused in the combinational build.
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst_n};

        assign Sum  = sum_d;
        assign Cout = carry[WIDTH];
    end

endmodule

// File: tb/tb_full_adder_using_mux.sv
// -----------------------------------------------------------------------------
// tb_full_adder_using_mux
//
// Exercises three configurations side by side:
//   u_w1  WIDTH=1, combinational (clock input held low)
//   u_w4  WIDTH=4, combinational
//   u_w4r WIDTH=4, registered outputs
// -----------------------------------------------------------------------------
module tb_full_adder_using_mux;

    int tests  = 0;
    int failed = 0;

    logic clk      = 1'b0;
    logic clk_lo   = 1'b0;
    logic rst_n    = 1'b0;
    logic rst_n_w1 = 1'b1;

    logic       a1, b1, cin1;
    logic       sum1, cout1;

    logic [3:0] a4, b4;
    logic       cin4;
    logic [3:0] sum4;
    logic       cout4;

    logic [3:0] a4r, b4r;
    logic       cin4r;
    logic [3:0] sum4r;
    logic       cout4r;

    always #5 clk = ~clk;

    full_adder_using_mux #(.WIDTH(1), .REGISTER_OUT(1'b0)) u_w1 (
        .clk   (clk_lo),
        .rst_n (rst_n_w1),
        .A     (a1),
        .B     (b1),
        .Cin   (cin1),
        .Sum   (sum1),
        .Cout  (cout1)
    );

    full_adder_using_mux #(.WIDTH(4), .REGISTER_OUT(1'b0)) u_w4 (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a4),
        .B     (b4),
        .Cin   (cin4),
        .Sum   (sum4),
        .Cout  (cout4)
    );

    full_adder_using_mux #(.WIDTH(4), .REGISTER_OUT(1'b1)) u_w4r (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (a4r),
        .B     (b4r),
        .Cin   (cin4r),
        .Sum   (sum4r),
        .Cout  (cout4r)
    );

    // Registered build: outputs stay 0 while reset is held, and the first edge
    // after release captures the current inputs (3+4+1 = 8).
    task automatic test_reset();
        @(negedge clk);
        a4r = 4'h3; b4r = 4'h4; cin4r = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({sum4r, cout4r} !== 5'b0) begin
            failed++;
            $display("FAIL reset_hold: got sum=%h cout=%b, want sum=0 cout=0", sum4r, cout4r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (sum4r !== 4'h8 || cout4r !== 1'b0) begin
            failed++;
            $display("FAIL reset_release_first_edge: got sum=%h cout=%b, want sum=8 cout=0", sum4r, cout4r);
        end
    endtask

    task automatic test_exhaustive_w1();
        logic [7:0] exp_sum;
        logic [7:0] exp_cout;
        logic [2:0] v;
        exp_sum  = 8'b1001_0110;
        exp_cout = 8'b1110_1000;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a1, b1, cin1} = v;
            #10;
            tests++;
            if (sum1 !== exp_sum[i] || cout1 !== exp_cout[i]) begin
                failed++;
                $display("FAIL w1_exhaustive abc=%b: got sum=%b cout=%b, want sum=%b cout=%b",
                         v, sum1, cout1, exp_sum[i], exp_cout[i]);
            end
        end
    endtask

    // Sum and Cout must track Cin immediately, and rst_n has no effect.
    task automatic test_cin_toggle_w1();
        a1 = 1'b1; b1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cin1     = i[0];
            rst_n_w1 = i[1];
            #1;
            tests++;
            if (sum1 !== ~i[0] || cout1 !== i[0]) begin
                failed++;
                $display("FAIL w1_cin_toggle step=%0d: got sum=%b cout=%b, want sum=%b cout=%b",
                         i, sum1, cout1, ~i[0], i[0]);
            end
        end
        rst_n_w1 = 1'b1;
    endtask

    task automatic test_w4_directed();
        a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1;
        #1;
        tests++;
        if (sum4 !== 4'h0 || cout4 !== 1'b1) begin
            failed++;
            $display("FAIL w4_full_ripple: got sum=%h cout=%b, want sum=0 cout=1", sum4, cout4);
        end
        a4 = 4'h5; b4 = 4'hA; cin4 = 1'b0;
        #1;
        tests++;
        if (sum4 !== 4'hF || cout4 !== 1'b0) begin
            failed++;
            $display("FAIL w4_5_plus_A: got sum=%h cout=%b, want sum=F cout=0", sum4, cout4);
        end
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        #1;
        tests++;
        if (sum4 !== 4'hF || cout4 !== 1'b1) begin
            failed++;
            $display("FAIL w4_all_ones: got sum=%h cout=%b, want sum=F cout=1", sum4, cout4);
        end
        a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
        #1;
        tests++;
        if (sum4 !== 4'h0 || cout4 !== 1'b0) begin
            failed++;
            $display("FAIL w4_all_zeros: got sum=%h cout=%b, want sum=0 cout=0", sum4, cout4);
        end
    endtask

    task automatic test_w4_sweep();
        logic [4:0] exp;
        for (int i = 0; i < 512; i++) begin
            a4   = 4'(i >> 5);
            b4   = 4'(i >> 1);
            cin4 = i[0];
            exp  = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
            #1;
            tests++;
            if ({cout4, sum4} !== exp) begin
                failed++;
                $display("FAIL w4_sweep a=%h b=%h cin=%b: got %b, want %b",
                         a4, b4, cin4, {cout4, sum4}, exp);
            end
        end
    endtask

    // One-cycle latency: new inputs are invisible until the next rising edge.
    task automatic test_registered();
        @(negedge clk);
        a4r = 4'h3; b4r = 4'h4; cin4r = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        a4r = 4'h1; b4r = 4'h1; cin4r = 1'b0;
        #1;
        tests++;
        if (sum4r !== 4'h8 || cout4r !== 1'b0) begin
            failed++;
            $display("FAIL reg_before_edge: got sum=%h cout=%b, want sum=8 cout=0", sum4r, cout4r);
        end
        @(posedge clk); #1;
        tests++;
        if (sum4r !== 4'h2 || cout4r !== 1'b0) begin
            failed++;
            $display("FAIL reg_after_edge: got sum=%h cout=%b, want sum=2 cout=0", sum4r, cout4r);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        a4r = 4'h3; b4r = 4'h4; cin4r = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (sum4r !== 4'h8 || cout4r !== 1'b0) begin
            failed++;
            $display("FAIL b2b_first: got sum=%h cout=%b, want sum=8 cout=0", sum4r, cout4r);
        end
        @(negedge clk);
        a4r = 4'hF; b4r = 4'hF; cin4r = 1'b1;
        #1;
        tests++;
        if (sum4r !== 4'h8 || cout4r !== 1'b0) begin
            failed++;
            $display("FAIL b2b_hold: got sum=%h cout=%b, want sum=8 cout=0", sum4r, cout4r);
        end
        @(posedge clk); #1;
        tests++;
        if (sum4r !== 4'hF || cout4r !== 1'b1) begin
            failed++;
            $display("FAIL b2b_second: got sum=%h cout=%b, want sum=F cout=1", sum4r, cout4r);
        end
    endtask

    // Outputs hold F/1 on entry. Reset asserted between edges clears them at
    // once; the first edge after release loads the current inputs (2+3+0 = 5).
    task automatic test_reset_mid();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        a4r = 4'h2; b4r = 4'h3; cin4r = 1'b0;
        #1;
        tests++;
        if (sum4r !== 4'h0 || cout4r !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid_async: got sum=%h cout=%b, want sum=0 cout=0", sum4r, cout4r);
        end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (sum4r !== 4'h0 || cout4r !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid_hold: got sum=%h cout=%b, want sum=0 cout=0", sum4r, cout4r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests++;
        if (sum4r !== 4'h0 || cout4r !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid_pre_edge: got sum=%h cout=%b, want sum=0 cout=0", sum4r, cout4r);
        end
        @(posedge clk); #1;
        tests++;
        if (sum4r !== 4'h5 || cout4r !== 1'b0) begin
            failed++;
            $display("FAIL reset_mid_reload: got sum=%h cout=%b, want sum=5 cout=0", sum4r, cout4r);
        end
    endtask

    initial begin
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
        a4r = 4'h0; b4r = 4'h0; cin4r = 1'b0;
        test_reset();
        test_exhaustive_w1();
        test_cin_toggle_w1();
        test_w4_directed();
        test_w4_sweep();
        test_registered();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/full_adder_using_mux.md
Name: full_adder_using_mux

Overview:
Full adder whose per-bit Sum and carry are built only from 4:1 multiplexer primitives, with no XOR/AND/OR gates in the sum/carry datapath. The default configuration is a single-bit, purely combinational adder used as a leaf cell in mux-based arithmetic. A WIDTH parameter ripples WIDTH mux-based cells. An optional output register stage uses the block's single clock and asynchronous active-low reset.

Parameters:
WIDTH, 1, operand width in bits; the number of rippled mux-based full-adder cells (must be >= 1).
REGISTER_OUT, 0, 0 = Sum/Cout purely combinational; 1 = Sum/Cout registered on rising clk.

Ports:
clk  input  1  single clock; used only when REGISTER_OUT=1; may be left tied when REGISTER_OUT=0.
rst_n  input  1  asynchronous active-low reset; clears output registers when REGISTER_OUT=1; no effect when REGISTER_OUT=0.
A  input  WIDTH  addend.
B  input  WIDTH  addend.
Cin  input  1  carry into bit 0.
Sum  output  WIDTH  sum bits, equal to (A + B + Cin) mod 2^WIDTH.
Cout  output  1  carry out of the MSB cell.

Behaviour:
- Mux primitive: a 4:1 mux submodule with a 2-bit select and data inputs d0..d3; out = d[sel]. Instantiate it explicitly; each cell uses exactly two instances.
- Per-cell mapping, bit i, with select = {A[i], B[i]} and c = carry into the cell:
  - Sum mux data d0..d3 = c, ~c, ~c, c.
  - Carry mux data d0..d3 = 0, c, c, 1.
- Cell 0 carry-in = Cin. The carry out of cell i feeds cell i+1. Cout = carry out of cell WIDTH-1.
- Arithmetic: {Cout, Sum} = A + B + Cin, exact with no overflow loss; the result is (WIDTH+1) bits.
- REGISTER_OUT=0:
  - Outputs are combinational with zero-cycle latency.
  - Outputs settle within one propagation delay of any input change.
  - No state is held; clk and rst_n are ignored.
- REGISTER_OUT=1:
  - Sum/Cout update on the rising edge of clk with one-cycle latency: the inputs present at edge N appear after edge N.
  - While rst_n=0, Sum=0 and Cout=0 immediately, independent of clk.
  - Reset asserted mid-operation clears the outputs asynchronously and discards any pending result.
  - On reset release, the first rising edge captures the current inputs.
- No X-propagation tolerance is required. With known inputs, outputs are always known.
- Boundary cases:
  - All-ones operands with Cin=1 give Sum = all ones and Cout=1.
  - All-zeros operands with Cin=0 give Sum=0 and Cout=0.
  - For WIDTH>1, carry ripples through the full chain, e.g. WIDTH=4: 4'hF + 4'h0 + 1 gives 4'h0 with carry 1.

Test Plan:
- WIDTH=1, REGISTER_OUT=0, exhaustive {A,B,Cin}=0..7, 10 ns per step. Required {Sum,Cout} per step: 000->0,0; 001->1,0; 010->1,0; 011->0,1; 100->1,0; 101->0,1; 110->0,1; 111->1,1.
- WIDTH=1, REGISTER_OUT=0: toggle Cin with A=1, B=0 and clk held low. Sum flips 0/1 and Cout follows Cin within the same timestep; rst_n toggling has no effect.
- WIDTH=4, REGISTER_OUT=0:
  - A=4'hF, B=4'h0, Cin=1 -> Sum=4'h0, Cout=1 (full ripple).
  - A=4'h5, B=4'hA, Cin=0 -> Sum=4'hF, Cout=0.
  - Random sweep of all 512 combinations matches A+B+Cin.
- WIDTH=4, REGISTER_OUT=1:
  - Apply A=4'h3, B=4'h4, Cin=1 before edge N. Sum=4'h8 and Cout=0 appear after edge N, not before.
  - Next change to A=4'hF, B=4'hF, Cin=1 gives Sum=4'hF and Cout=1 one edge later.
- REGISTER_OUT=1, reset mid-operation: with outputs holding Sum=4'hF, Cout=1, drive rst_n low between edges. Outputs go to 0 immediately and stay 0 across edges while low. After release, the first edge loads the current inputs.
- Structural check, any WIDTH: exactly 2*WIDTH 4:1 mux instances, and no gate-level logic drives Sum or the carry chain.
